// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel-clock divider, horizontal/vertical counters,
// sync generation and a small built-in test-pattern source. Colour and syncs
// are registered on the pixel strobe, one pixel behind the counters.
module vga_timing_gen #(
    parameter int H_ACTIVE      = 640,
    parameter int H_FRONT       = 16,
    parameter int H_SYNC        = 96,
    parameter int H_BACK        = 48,
    parameter int V_ACTIVE      = 480,
    parameter int V_FRONT       = 10,
    parameter int V_SYNC        = 2,
    parameter int V_BACK        = 33,
    parameter int SYNC_POLARITY = 0,
    parameter int CLOCK_DIVIDE  = 4,
    parameter int COLOR_WIDTH   = 4,
    parameter int COORD_WIDTH   = 12
) (
    input  logic                   clock,
    input  logic                   resetN,
    input  logic                   enable,
    input  logic [1:0]             patternSelect,
    input  logic [COLOR_WIDTH-1:0] pixelRed,
    input  logic [COLOR_WIDTH-1:0] pixelGreen,
    input  logic [COLOR_WIDTH-1:0] pixelBlue,
    output logic [COORD_WIDTH-1:0] pixelX,
    output logic [COORD_WIDTH-1:0] pixelY,
    output logic                   videoActive,
    output logic                   pixelEnable,
    output logic                   lineStart,
    output logic                   frameStart,
    output logic [COLOR_WIDTH-1:0] red,
    output logic [COLOR_WIDTH-1:0] green,
    output logic [COLOR_WIDTH-1:0] blue,
    output logic                   horizontalSync,
    output logic                   verticalSync
);

    localparam int H_TOTAL   = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL   = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W     = (CLOCK_DIVIDE > 1) ? $clog2(CLOCK_DIVIDE) : 1;
    localparam int BAR_WIDTH = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

    localparam logic [DIV_W-1:0]       DIV_LAST     = DIV_W'(CLOCK_DIVIDE - 1);
    localparam logic [COORD_WIDTH-1:0] H_LAST       = COORD_WIDTH'(H_TOTAL - 1);
    localparam logic [COORD_WIDTH-1:0] V_LAST       = COORD_WIDTH'(V_TOTAL - 1);
    localparam logic [COORD_WIDTH-1:0] H_ACT        = COORD_WIDTH'(H_ACTIVE);
    localparam logic [COORD_WIDTH-1:0] V_ACT        = COORD_WIDTH'(V_ACTIVE);
    localparam logic [COORD_WIDTH-1:0] H_SYNC_FIRST = COORD_WIDTH'(H_ACTIVE + H_FRONT);
    localparam logic [COORD_WIDTH-1:0] H_SYNC_LAST  = COORD_WIDTH'(H_ACTIVE + H_FRONT + H_SYNC - 1);
    localparam logic [COORD_WIDTH-1:0] V_SYNC_FIRST = COORD_WIDTH'(V_ACTIVE + V_FRONT);
    localparam logic [COORD_WIDTH-1:0] V_SYNC_LAST  = COORD_WIDTH'(V_ACTIVE + V_FRONT + V_SYNC - 1);
    localparam logic [COORD_WIDTH-1:0] BAR_DIV      = COORD_WIDTH'(BAR_WIDTH);
    localparam logic [COORD_WIDTH-1:0] BAR_MAX      = COORD_WIDTH'(7);
    localparam logic                   SYNC_ON      = (SYNC_POLARITY != 0);
    localparam logic [COLOR_WIDTH-1:0] COLOR_ONES   = {COLOR_WIDTH{1'b1}};

    logic [DIV_W-1:0]       div_reg, div_next;
    logic [COORD_WIDTH-1:0] h_count_reg, h_count_next;
    logic [COORD_WIDTH-1:0] v_count_reg, v_count_next;
    logic [1:0]             pattern_reg, pattern_next;
    logic [1:0]             pattern_active;
    logic                   hsync_reg, hsync_next;
    logic                   vsync_reg, vsync_next;

    // Channel order inside packed colour vectors: [0]=red, [1]=green, [2]=blue
    logic [2:0][COLOR_WIDTH-1:0] color_reg, color_next;
    logic [2:0][COLOR_WIDTH-1:0] ext_color;
    logic [2:0]                  bar_on;

    logic                   pixel_strobe, line_start, frame_start, video_active;
    logic [COORD_WIDTH-1:0] bar_quot;
    logic [2:0]             bar_index;
    logic                   checker_on;

    assign pixel_strobe = enable && (div_reg == DIV_LAST);
    assign line_start   = pixel_strobe && (h_count_reg == '0);
    assign frame_start  = line_start && (v_count_reg == '0);
    assign video_active = (h_count_reg < H_ACT) && (v_count_reg < V_ACT);

    // The pattern sampled at the frame origin already applies to pixel (0,0)
    assign pattern_active = frame_start ? patternSelect : pattern_reg;
    assign pattern_next   = pattern_active;

    // Divider and raster counters: next-state; enable low parks everything at the origin
    always_comb begin
        div_next     = div_reg;
        h_count_next = h_count_reg;
        v_count_next = v_count_reg;
        if (!enable) begin
            div_next     = '0;
            h_count_next = '0;
            v_count_next = '0;
        end else begin
            div_next = (div_reg == DIV_LAST) ? '0 : div_reg + 1'b1;
            if (pixel_strobe) begin
                if (h_count_reg == H_LAST) begin
                    h_count_next = '0;
                    v_count_next = (v_count_reg == V_LAST) ? '0 : v_count_reg + 1'b1;
                end else begin
                    h_count_next = h_count_reg + 1'b1;
                end
            end
        end
    end

    // Sync levels for the pixel currently addressed by the counters
    assign hsync_next = ((h_count_reg >= H_SYNC_FIRST) && (h_count_reg <= H_SYNC_LAST)) ? SYNC_ON : ~SYNC_ON;
    assign vsync_next = ((v_count_reg >= V_SYNC_FIRST) && (v_count_reg <= V_SYNC_LAST)) ? SYNC_ON : ~SYNC_ON;

    // Colour-bar index: eight equal bars, anything right of the last one stays in bar 7
    assign bar_quot  = h_count_reg / BAR_DIV;
    assign bar_index = (bar_quot > BAR_MAX) ? 3'd7 : bar_quot[2:0];
    // Bar order white, yellow, cyan, green, magenta, red, blue, black
    assign bar_on[0] = ~bar_index[1];
    assign bar_on[1] = ~bar_index[2];
    assign bar_on[2] = ~bar_index[0];

    assign checker_on = h_count_reg[5] ^ v_count_reg[5];
    assign ext_color  = {pixelBlue, pixelGreen, pixelRed};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_channel
            assign color_next[gi] = !video_active              ? '0 :
                                    (pattern_active == 2'd0)   ? ext_color[gi] :
                                    (pattern_active == 2'd1)   ? {COLOR_WIDTH{bar_on[gi]}} :
                                    (pattern_active == 2'd2)   ? {COLOR_WIDTH{checker_on}} :
                                                                 COLOR_ONES;
        end
    endgenerate

    // Timing state and pattern register
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            div_reg     <= '0;
            h_count_reg <= '0;
            v_count_reg <= '0;
            pattern_reg <= '0;
        end else begin
            div_reg     <= div_next;
            h_count_reg <= h_count_next;
            v_count_reg <= v_count_next;
            pattern_reg <= pattern_next;
        end
    end

    // Registered VGA outputs: updated on each pixel strobe, forced idle while disabled
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            color_reg <= '0;
            hsync_reg <= ~SYNC_ON;
            vsync_reg <= ~SYNC_ON;
        end else if (!enable) begin
            color_reg <= '0;
            hsync_reg <= ~SYNC_ON;
            vsync_reg <= ~SYNC_ON;
        end else if (pixel_strobe) begin
            color_reg <= color_next;
            hsync_reg <= hsync_next;
            vsync_reg <= vsync_next;
        end
    end

    assign pixelX         = h_count_reg;
    assign pixelY         = v_count_reg;
    assign videoActive    = video_active;
    assign pixelEnable    = pixel_strobe;
    assign lineStart      = line_start;
    assign frameStart     = frame_start;
    assign red            = color_reg[0];
    assign green          = color_reg[1];
    assign blue           = color_reg[2];
    assign horizontalSync = hsync_reg;
    assign verticalSync   = vsync_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen: a tiny raster (one clock per pixel) checked
// against a hand-computed vector table, plus a default-parameter instance for
// the 640x480 line timing, bars, checkerboard, reset and enable behaviour.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Small instance: 14 clocks per line, 7 lines per frame, active-high syncs
    logic        s_rst_n, s_en;
    logic [1:0]  s_pat;
    logic [3:0]  s_pr, s_pg, s_pb;
    logic [11:0] s_x, s_y;
    logic        s_act, s_pe, s_ls, s_fs, s_hs, s_vs;
    logic [3:0]  s_r, s_g, s_b;

    // External pixel source: {pixelX[3:0], pixelY[3:0], 5}
    assign s_pr = s_x[3:0];
    assign s_pg = s_y[3:0];
    assign s_pb = 4'd5;

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .SYNC_POLARITY(1), .CLOCK_DIVIDE(1)
    ) u_small (
        .clock(clk), .resetN(s_rst_n), .enable(s_en), .patternSelect(s_pat),
        .pixelRed(s_pr), .pixelGreen(s_pg), .pixelBlue(s_pb),
        .pixelX(s_x), .pixelY(s_y), .videoActive(s_act), .pixelEnable(s_pe),
        .lineStart(s_ls), .frameStart(s_fs), .red(s_r), .green(s_g), .blue(s_b),
        .horizontalSync(s_hs), .verticalSync(s_vs)
    );

    // Default instance: 640x480, divide by 4, active-low syncs
    logic        d_rst_n, d_en;
    logic [1:0]  d_pat;
    logic [3:0]  d_pr, d_pg, d_pb;
    logic [11:0] d_x, d_y;
    logic        d_act, d_pe, d_ls, d_fs, d_hs, d_vs;
    logic [3:0]  d_r, d_g, d_b;

    assign d_pr = 4'h0;
    assign d_pg = 4'h0;
    assign d_pb = 4'h0;

    vga_timing_gen u_def (
        .clock(clk), .resetN(d_rst_n), .enable(d_en), .patternSelect(d_pat),
        .pixelRed(d_pr), .pixelGreen(d_pg), .pixelBlue(d_pb),
        .pixelX(d_x), .pixelY(d_y), .videoActive(d_act), .pixelEnable(d_pe),
        .lineStart(d_ls), .frameStart(d_fs), .red(d_r), .green(d_g), .blue(d_b),
        .horizontalSync(d_hs), .verticalSync(d_vs)
    );

    int total = 0;
    int bad   = 0;
    int s_n   = 0;

    typedef struct {
        int          n;
        logic [11:0] x;
        logic [11:0] y;
        logic        act, pe, ls, fs, hs, vs;
        logic [11:0] rgb;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input int n, input int x, input int y,
                                input bit act, input bit pe, input bit ls, input bit fs,
                                input bit hs, input bit vs, input logic [11:0] rgb);
        vec_t v;
        v.n = n; v.x = 12'(x); v.y = 12'(y);
        v.act = act; v.pe = pe; v.ls = ls; v.fs = fs; v.hs = hs; v.vs = vs;
        v.rgb = rgb;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic s_step_to(input int target);
        while (s_n < target) begin
            @(posedge clk);
            #1;
            s_n++;
        end
    endtask

    task automatic d_step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for the pixel strobe at (x,y) on the default instance
    task automatic d_wait_pix(input int x, input int y);
        int k = 0;
        while (!(d_pe && d_x == 12'(x) && d_y == 12'(y)) && k < 5000) begin
            d_step();
            k++;
        end
        if (k >= 5000) begin
            total++;
            bad++;
            $display("FAIL wait_pix(%0d,%0d): got timeout expected strobe", x, y);
        end
    endtask

    // Colour registered for the strobe the bench is currently sitting on
    task automatic d_color(input string name, input logic [11:0] exp);
        d_step();
        chk(name, {d_r, d_g, d_b}, exp);
    endtask

    // Called in the first cycle after a resume; frameStart must appear in cycle 4
    task automatic d_start(input string name);
        int c = 1;
        while (!d_fs && c < 20) begin
            d_step();
            c++;
        end
        chk({name, "_cycle"}, c, 4);
        chk({name, "_origin"}, {d_x, d_y}, 24'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int low, period, k, glitches;

        // n, x, y, act, pe, ls, fs, hs, vs, rgb (registered values reflect pixel n-1)
        tbl.push_back(mk(  0,  0, 0, 1, 1, 1, 1, 0, 0, 12'h000));
        tbl.push_back(mk(  1,  1, 0, 1, 1, 0, 0, 0, 0, 12'hFFF));
        tbl.push_back(mk(  2,  2, 0, 1, 1, 0, 0, 0, 0, 12'hFF0));
        tbl.push_back(mk(  3,  3, 0, 1, 1, 0, 0, 0, 0, 12'h0FF));
        tbl.push_back(mk(  5,  5, 0, 1, 1, 0, 0, 0, 0, 12'hF0F));
        tbl.push_back(mk(  7,  7, 0, 1, 1, 0, 0, 0, 0, 12'h00F));
        tbl.push_back(mk(  8,  8, 0, 0, 1, 0, 0, 0, 0, 12'h000));
        tbl.push_back(mk(  9,  9, 0, 0, 1, 0, 0, 0, 0, 12'h000));
        tbl.push_back(mk( 11, 11, 0, 0, 1, 0, 0, 1, 0, 12'h000));
        tbl.push_back(mk( 12, 12, 0, 0, 1, 0, 0, 1, 0, 12'h000));
        tbl.push_back(mk( 13, 13, 0, 0, 1, 0, 0, 0, 0, 12'h000));
        tbl.push_back(mk( 14,  0, 1, 1, 1, 1, 0, 0, 0, 12'h000));
        tbl.push_back(mk( 15,  1, 1, 1, 1, 0, 0, 0, 0, 12'hFFF));
        tbl.push_back(mk( 56,  0, 4, 0, 1, 1, 0, 0, 0, 12'h000));
        tbl.push_back(mk( 57,  1, 4, 0, 1, 0, 0, 0, 0, 12'h000));
        tbl.push_back(mk( 70,  0, 5, 0, 1, 1, 0, 0, 0, 12'h000));
        tbl.push_back(mk( 71,  1, 5, 0, 1, 0, 0, 0, 1, 12'h000));
        tbl.push_back(mk( 81, 11, 5, 0, 1, 0, 0, 1, 1, 12'h000));
        tbl.push_back(mk( 84,  0, 6, 0, 1, 1, 0, 0, 1, 12'h000));
        tbl.push_back(mk( 85,  1, 6, 0, 1, 0, 0, 0, 0, 12'h000));
        tbl.push_back(mk( 98,  0, 0, 1, 1, 1, 1, 0, 0, 12'h000));
        tbl.push_back(mk( 99,  1, 0, 1, 1, 0, 0, 0, 0, 12'hFFF));
        tbl.push_back(mk(112,  0, 1, 1, 1, 1, 0, 0, 0, 12'h000));

        s_rst_n = 1'b0; s_en = 1'b0; s_pat = 2'd0;
        d_rst_n = 1'b0; d_en = 1'b0; d_pat = 2'd0;
        repeat (3) @(posedge clk);
        #1;

        // ---------------- small instance ----------------
        chk("small_reset", {s_x, s_y, s_hs, s_vs, s_r, s_g, s_b, s_pe}, 40'd0);

        s_rst_n = 1'b1; s_en = 1'b1; s_pat = 2'd1;
        s_n = 0;
        #1;
        foreach (tbl[i]) begin
            s_step_to(tbl[i].n);
            chk($sformatf("vec n=%0d", tbl[i].n),
                {22'd0, s_x, s_y, s_act, s_pe, s_ls, s_fs, s_hs, s_vs, s_r, s_g, s_b},
                {22'd0, tbl[i].x, tbl[i].y, tbl[i].act, tbl[i].pe, tbl[i].ls, tbl[i].fs,
                 tbl[i].hs, tbl[i].vs, tbl[i].rgb});
        end

        // Pattern change mid-frame only takes effect at the next frame origin
        s_pat = 2'd2;
        s_step_to(128);  chk("pat_hold_bars",  {s_r, s_g, s_b}, 12'hFF0);
        s_step_to(198);  chk("pat_checker",    {s_r, s_g, s_b}, 12'h000);
        s_pat = 2'd3;
        s_step_to(296);  chk("pat_solid_x1",   {s_r, s_g, s_b}, 12'hFFF);
        s_step_to(302);  chk("pat_solid_x7",   {s_r, s_g, s_b}, 12'hFFF);
        s_step_to(304);  chk("pat_solid_blank",{s_r, s_g, s_b}, 12'h000);
        s_pat = 2'd0;
        s_step_to(424);  chk("ext_3_2",        {s_r, s_g, s_b}, 12'h325);
        s_step_to(429);  chk("ext_blank",      {s_r, s_g, s_b}, 12'h000);
        s_step_to(442);  chk("ext_7_3",        {s_r, s_g, s_b}, 12'h735);

        // ---------------- default instance ----------------
        chk("def_reset", {d_hs, d_vs, d_r, d_g, d_b, d_x, d_y, d_pe}, {2'b11, 12'h000, 24'd0, 1'b0});

        d_rst_n = 1'b1; d_en = 1'b1; d_pat = 2'd1;
        #1;
        d_start("def_first_frame");

        d_color("bar_x0", 12'hFFF);
        d_wait_pix(80, 0);   d_color("bar_x80",  12'hFF0);
        d_wait_pix(559, 0);  d_color("bar_x559", 12'h00F);
        d_wait_pix(560, 0);  d_color("bar_x560", 12'h000);
        d_wait_pix(640, 0);  d_color("blank_x640", 12'h000);
        d_wait_pix(799, 0);  d_color("blank_x799", 12'h000);

        // Horizontal sync: low pulse width and fall-to-fall period in clocks
        k = 0;
        while (d_hs !== 1'b0 && k < 5000) begin d_step(); k++; end
        low = 0;
        while (d_hs === 1'b0 && low < 5000) begin d_step(); low++; end
        period = low;
        while (d_hs === 1'b1 && period < 8000) begin d_step(); period++; end
        chk("hsync_low_clocks", low, 384);
        chk("hsync_period_clocks", period, 3200);
        chk("vsync_idle_line2", d_vs, 1'b1);

        // Asynchronous reset in the middle of an hsync pulse
        d_rst_n = 1'b0;
        #1;
        chk("async_reset_idle", {d_hs, d_vs, d_r, d_g, d_b, d_x, d_y, d_pe}, {2'b11, 12'h000, 24'd0, 1'b0});
        d_pat = 2'd2;
        d_step();
        d_rst_n = 1'b1;
        #1;
        d_start("after_reset");

        d_color("checker_x0", 12'h000);
        d_wait_pix(32, 0);  d_color("checker_x32", 12'hFFF);
        d_wait_pix(64, 0);  d_color("checker_x64", 12'h000);
        d_wait_pix(96, 0);  d_color("checker_x96", 12'hFFF);

        // Enable low for 10 clocks: idle outputs, no strobes
        d_en = 1'b0;
        d_step();
        chk("enable_low_idle", {d_hs, d_vs, d_r, d_g, d_b, d_x, d_y}, {2'b11, 12'h000, 24'd0});
        glitches = 0;
        repeat (9) begin
            d_step();
            if (d_pe || d_ls || d_fs) glitches++;
        end
        chk("enable_low_strobes", glitches, 0);
        d_pat = 2'd3;
        d_en  = 1'b1;
        #1;
        d_start("after_enable");
        d_color("resume_solid_x0", 12'hFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- H_ACTIVE, 640, visible pixels per line
- H_FRONT / H_SYNC / H_BACK, 16 / 96 / 48, horizontal porch and sync widths in pixels
- V_ACTIVE, 480, visible lines per frame
- V_FRONT / V_SYNC / V_BACK, 10 / 2 / 33, vertical porch and sync widths in lines
- SYNC_POLARITY, 0, asserted sync level (0 = active-low)
- CLOCK_DIVIDE, 4, clock cycles per pixel (>=1)
- COLOR_WIDTH, 4, bits per colour channel
- COORD_WIDTH, 12, width of the pixel coordinate outputs

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clock, in, 1, single system clock
- resetN, in, 1, asynchronous active-low reset
- enable, in, 1, timing run; low = idle
- patternSelect, in, 2, 0 external, 1 colour bars, 2 checkerboard, 3 solid white
- pixelRed/pixelGreen/pixelBlue, in, COLOR_WIDTH, external pixel colour for current pixelX/pixelY
- pixelX/pixelY, out, COORD_WIDTH, current horizontal/vertical counter
- videoActive, out, 1, current counters inside the visible area
- pixelEnable, out, 1, one-clock pixel strobe
- lineStart/frameStart, out, 1, one-clock strobes at line/frame origin
- red/green/blue, out, COLOR_WIDTH, registered VGA colour
- horizontalSync/verticalSync, out, 1, registered VGA syncs

Function
REQ-003 H_TOTAL SHALL equal H_ACTIVE+H_FRONT+H_SYNC+H_BACK; V_TOTAL SHALL equal V_ACTIVE+V_FRONT+V_SYNC+V_BACK.
REQ-004 The divider SHALL count 0..CLOCK_DIVIDE-1 and wrap; pixelEnable SHALL be high for exactly the cycle with divider = CLOCK_DIVIDE-1; with CLOCK_DIVIDE=1, pixelEnable SHALL be high every cycle while enable=1.
REQ-005 On pixelEnable, hCount SHALL increment and wrap H_TOTAL-1 -> 0. vCount SHALL increment only on that wrap, and SHALL wrap V_TOTAL-1 -> 0.
REQ-006 pixelX=hCount and pixelY=vCount (combinational from counters); videoActive = (hCount<H_ACTIVE)&&(vCount<V_ACTIVE).
REQ-007 lineStart SHALL equal pixelEnable&&hCount==0; frameStart SHALL equal lineStart&&vCount==0.
REQ-008 Colour and sync outputs SHALL register on pixelEnable with one pixel of latency. Values on red/green/blue/syncs after strobe n SHALL correspond to the counters at strobe n.
REQ-009 horizontalSync SHALL equal SYNC_POLARITY when hCount is in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC-1], else ~SYNC_POLARITY. verticalSync SHALL follow the same rule on vCount with the V_ parameters.
REQ-010 When videoActive=0, the registered colour SHALL be 0 on all channels, regardless of pattern.
REQ-011 Pattern 0: colour SHALL be pixelRed/pixelGreen/pixelBlue.
REQ-012 Pattern 1: bar index k = pixelX/(H_ACTIVE/8), constant-divided, clamped to 7.
- Bars 0..7 SHALL be white, yellow, cyan, green, magenta, red, blue, black.
- Channels SHALL be all-ones or zero.
REQ-013 Pattern 2: white when pixelX[5]^pixelY[5]=1, else black. Pattern 3: white everywhere active.
REQ-014 patternSelect SHALL be sampled into an internal register only on frameStart; mid-frame changes SHALL take effect at the next frame origin.
REQ-015 enable=0 SHALL synchronously:
- clear divider and counters
- hold pixelEnable/lineStart/frameStart low
- drive colour 0 and syncs ~SYNC_POLARITY
REQ-016 After enable rises, the first pixelEnable SHALL occur CLOCK_DIVIDE cycles later, with counters at (0,0) and frameStart asserted.

Reset
REQ-017 resetN=0 SHALL asynchronously clear the divider, counters, colour outputs and pattern register (to 0), and drive syncs to ~SYNC_POLARITY.
REQ-018 Reset release SHALL behave identically to an enable rise (REQ-016); reset mid-frame SHALL restart the frame at (0,0) with no partial sync pulse carried over.

Verification
REQ-019 Defaults, enable=1, 10 ns clock -> hsync period 3200 clocks, low 384 clocks; vsync period 1,680,000 clocks, low 6400 clocks; frameStart once per 1,680,000 clocks.
REQ-020 Pattern 1, defaults -> first-line output at pixelX 0 = (F,F,F), pixelX 80 = (F,F,0), pixelX 560 = (0,0,0). Output is 0 at pixelX 640..799 and on all lines >= 480.
REQ-021 Pattern 0 with pixel inputs = {pixelX[3:0], pixelY[3:0], 5} -> outputs match the inputs delayed one pixel strobe, and are zero in blanking.
REQ-022 CLOCK_DIVIDE=1, H_ACTIVE=8, H_FRONT=H_SYNC=H_BACK=2, V_ACTIVE=4, V_FRONT=V_SYNC=V_BACK=1, SYNC_POLARITY=1 -> line 14 clocks, frame 98 clocks; hsync high during hCount 10..11, registered one cycle later.
REQ-023 resetN pulsed low at pixelY=200, then enable toggled low for 10 clocks -> after each, outputs idle, syncs 1 (defaults), and frameStart occurs CLOCK_DIVIDE cycles after resume.
REQ-024 patternSelect changed 1->2 at pixelY=100 -> bars persist to frame end; checkerboard from next frameStart.
